// File: rtl/mult_repadd_seq.sv
// -----------------------------------------------------------------------------
// mult_repadd_seq
//   Unsigned multiplier by repeated addition. A multiplicand register M is
//   added into a 2*WIDTH accumulator once per clock while a down-counter
//   (loaded with the other operand) runs to zero. With SWAP_MIN=1 the smaller
//   operand is used as the count, so the operation takes min(a,b) adds.
//
//   Parameters
//     WIDTH     operand width; product is 2*WIDTH bits
//     SWAP_MIN  1: count with min(a,b), add max(a,b); 0: add a, count b
//
//   Ports
//     i_clk      rising-edge clock
//     i_rst_n    asynchronous active-low reset
//     i_start    request, accepted only while o_ready=1
//     i_abort    cancels an operation in RUN (no done, product cleared)
//     i_a_in     operand A, sampled on the accepting edge only
//     i_b_in     operand B, sampled on the accepting edge only
//     o_ready    high in IDLE
//     o_busy     high in RUN
//     o_done     one-cycle pulse, product valid
//     o_product  result, held from done until replaced by a later operation
//
//   Timing: start accepted at edge k with count N -> o_done high after edge
//   k+N+1, back in IDLE after edge k+N+2.
// -----------------------------------------------------------------------------
module mult_repadd_seq #(
  parameter int WIDTH    = 8,
  parameter bit SWAP_MIN = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [WIDTH-1:0]   i_a_in,
  input  logic [WIDTH-1:0]   i_b_in,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     w_m_nxt;
  logic [WIDTH-1:0]     r_cnt;
  logic [WIDTH-1:0]     w_cnt_nxt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [2*WIDTH-1:0]   r_product;
  logic [2*WIDTH-1:0]   w_product_nxt;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_swap;

  // Swap only on a strict less-than so that ties keep M = a.
  assign w_swap = SWAP_MIN && (i_a_in < i_b_in);

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    w_state_nxt   = r_state;
    w_m_nxt       = r_m;
    w_cnt_nxt     = r_cnt;
    w_acc_nxt     = r_acc;
    w_product_nxt = r_product;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_m_nxt     = w_swap ? i_b_in : i_a_in;
          w_cnt_nxt   = w_swap ? i_a_in : i_b_in;
          w_acc_nxt   = {(2*WIDTH){1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Abort wins over both completion and another add.
        if (i_abort) begin
          w_state_nxt   = ST_IDLE;
          w_product_nxt = {(2*WIDTH){1'b0}};
        end else if (r_cnt == {WIDTH{1'b0}}) begin
          w_state_nxt   = ST_DONE;
          w_product_nxt = r_acc;
        end else begin
          w_acc_nxt = r_acc + {{WIDTH{1'b0}}, r_m};
          w_cnt_nxt = r_cnt - {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; status flags decoded from next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_m       <= {WIDTH{1'b0}};
      r_cnt     <= {WIDTH{1'b0}};
      r_acc     <= {(2*WIDTH){1'b0}};
      r_product <= {(2*WIDTH){1'b0}};
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_m       <= w_m_nxt;
      r_cnt     <= w_cnt_nxt;
      r_acc     <= w_acc_nxt;
      r_product <= w_product_nxt;
      r_ready   <= (w_state_nxt == ST_IDLE);
      r_busy    <= (w_state_nxt == ST_RUN);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  assign o_ready   = r_ready;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_product;

endmodule
